// File: rtl/scan_sequencer_pkg.sv
// Shared types and code arithmetic for the scan sequencer and its sub-blocks.
package scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_MANUAL = 2'd2
  } scan_state_t;

  typedef logic [1:0] sel_code_t;

  localparam sel_code_t CODE_FIRST = 2'd0;
  localparam sel_code_t CODE_LAST  = 2'd3;

  function automatic sel_code_t next_code(sel_code_t c, logic dir);
    sel_code_t n;
    if (dir) begin
      n = c - 2'd1;
    end else begin
      n = c + 2'd1;
    end
    return n;
  endfunction

  // An advance wraps when it leaves the last code in the current direction.
  function automatic logic is_wrap(sel_code_t c, logic dir);
    logic w;
    if (dir) begin
      w = (c == CODE_FIRST);
    end else begin
      w = (c == CODE_LAST);
    end
    return w;
  endfunction

endpackage

// File: rtl/scan_sequencer_if.sv
// Control inputs and select/status outputs of the scan sequencer, bundled as one port.
interface scan_sequencer_if;
  import scan_pkg::*;

  logic      en;
  logic      auto_mode;
  logic      dir;
  logic      step;
  logic      load;
  sel_code_t load_code;
  logic      x;
  logic      y;
  sel_code_t code;
  logic      code_valid;
  logic      change;
  logic      wrap;

  modport master (
    output en, auto_mode, dir, step, load, load_code,
    input  x, y, code, code_valid, change, wrap
  );

  modport slave (
    input  en, auto_mode, dir, step, load, load_code,
    output x, y, code, code_valid, change, wrap
  );

endinterface

// File: rtl/scan_sequencer_dwell_timer.sv
// Dwell counter: counts 0..DWELL-1 while running and flags the last count.
module scan_dwell_timer #(
  parameter int DWELL   = 4,
  parameter int DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam logic [DWELL_W-1:0] LAST_COUNT = DWELL_W'(DWELL - 1);
  localparam logic [DWELL_W-1:0] ONE        = DWELL_W'(1);
  localparam logic [DWELL_W-1:0] ZERO       = DWELL_W'(0);

  logic [DWELL_W-1:0] count_r;

  assign tick = run && (count_r == LAST_COUNT);

  // Counter register; clear wins over counting, and the count rolls over on tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= ZERO;
    end else if (clr) begin
      count_r <= ZERO;
    end else if (run) begin
      count_r <= tick ? ZERO : (count_r + ONE);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// Select-code sequencer feeding a 2-to-4 one-hot decoder: timed or manual stepping,
// direction control, direct load, and change/wrap strobes.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DWELL   = 4,
  parameter int DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  scan_sequencer_if.slave  bus
);

  scan_state_t state_r;
  scan_state_t state_s;
  sel_code_t   code_r;
  sel_code_t   code_s;
  logic        step_prev_r;
  logic        valid_r;
  logic        change_r;
  logic        wrap_r;
  logic        tick_s;
  logic        clr_s;
  logic        run_s;
  logic        adv_s;
  logic        load_s;
  logic        wrap_s;

  scan_dwell_timer #(
    .DWELL   (DWELL),
    .DWELL_W (DWELL_W)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_s),
    .run   (run_s),
    .tick  (tick_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: en gates everything, auto_mode picks the running state.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_SCAN, ST_MANUAL: begin
        if (!bus.en) begin
          state_s = ST_IDLE;
        end else if (bus.auto_mode) begin
          state_s = ST_SCAN;
        end else begin
          state_s = ST_MANUAL;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Advance/load decision; advances happen only while staying in the same running state.
  always_comb begin
    adv_s  = 1'b0;
    load_s = bus.load && bus.en && (state_r != ST_IDLE);
    if ((state_s == state_r) && (state_r == ST_SCAN)) begin
      adv_s = tick_s;
    end else if ((state_s == state_r) && (state_r == ST_MANUAL)) begin
      adv_s = bus.step && !step_prev_r;
    end else begin
      adv_s = 1'b0;
    end

    code_s = code_r;
    if (load_s) begin
      code_s = bus.load_code;
    end else if (adv_s) begin
      code_s = next_code(code_r, bus.dir);
    end else begin
      code_s = code_r;
    end

    wrap_s = adv_s && !load_s && is_wrap(code_r, bus.dir);
    clr_s  = (state_s != state_r) || load_s;
    run_s  = (state_r == ST_SCAN);
  end

  // Code register, step history and registered status strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_r      <= CODE_FIRST;
      step_prev_r <= 1'b0;
      valid_r     <= 1'b0;
      change_r    <= 1'b0;
      wrap_r      <= 1'b0;
    end else begin
      code_r      <= code_s;
      step_prev_r <= bus.step;
      valid_r     <= (state_s != ST_IDLE);
      change_r    <= (code_s != code_r);
      wrap_r      <= wrap_s;
    end
  end

  assign bus.code       = code_r;
  assign bus.x          = code_r[1];
  assign bus.y          = code_r[0];
  assign bus.code_valid = valid_r;
  assign bus.change     = change_r;
  assign bus.wrap       = wrap_r;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer (DWELL=4) with a cycle-level reference model.
module tb_scan_sequencer;

  localparam int DWELL = 4;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  scan_sequencer_if sif ();

  scan_sequencer #(.DWELL(DWELL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // mode: 0 = not running, 1 = timed, 2 = manual; held = cycles since code/mode entry.
  typedef struct {
    int code;
    int valid;
    int change;
    int wrap;
    int mode;
    int held;
    int prev_step;
  } model_t;

  model_t m;

  function automatic model_t model_step(model_t s, int en, int am, int dir, int step,
                                        int load, int load_code);
    model_t n = s;
    int new_mode = (en == 0) ? 0 : ((am != 0) ? 1 : 2);
    int advance = 0;
    n.wrap = 0;
    if (new_mode != 0 && s.mode != 0 && load != 0) begin
      n.code = load_code;
      n.held = 0;
    end else if (new_mode != s.mode) begin
      n.held = 0;
    end else if (new_mode == 1) begin
      n.held = s.held + 1;
      if (n.held == DWELL) begin
        advance = 1;
        n.held = 0;
      end
    end else if (new_mode == 2 && step != 0 && s.prev_step == 0) begin
      advance = 1;
    end
    if (advance != 0) begin
      n.code = (dir != 0) ? (s.code + 3) % 4 : (s.code + 1) % 4;
      n.wrap = (dir != 0) ? int'(s.code == 0) : int'(s.code == 3);
    end
    n.change    = int'(n.code != s.code);
    n.valid     = int'(new_mode != 0);
    n.mode      = new_mode;
    n.prev_step = step;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m <= '{default: 0};
    end else begin
      m <= model_step(m, int'(sif.en), int'(sif.auto_mode), int'(sif.dir), int'(sif.step),
                      int'(sif.load), int'(sif.load_code));
    end
  end

  task automatic chk(string name, int act, int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("cmp_code",   int'(sif.code),       m.code);
      chk("cmp_x",      int'(sif.x),          m.code / 2);
      chk("cmp_y",      int'(sif.y),          m.code % 2);
      chk("cmp_valid",  int'(sif.code_valid), m.valid);
      chk("cmp_change", int'(sif.change),     m.change);
      chk("cmp_wrap",   int'(sif.wrap),       m.wrap);
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    sif.en = 1'b0;
    sif.auto_mode = 1'b0;
    sif.dir = 1'b0;
    sif.step = 1'b0;
    sif.load = 1'b0;
    sif.load_code = 2'd0;
    cyc(2);
    chk("rst_code", int'(sif.code), 0);
    chk("rst_valid", int'(sif.code_valid), 0);
    rst_n = 1'b1;
    cyc(2);

    // Timed scan up: E0 at the next rising edge.
    sif.en = 1'b1;
    sif.auto_mode = 1'b1;
    cyc(1);
    chk("up_valid_e0", int'(sif.code_valid), 1);
    chk("up_code_e0", int'(sif.code), 0);
    cyc(3);
    chk("up_code_e3", int'(sif.code), 0);
    chk("up_change_e3", int'(sif.change), 0);
    cyc(1);
    chk("up_code_e4", int'(sif.code), 1);
    chk("up_change_e4", int'(sif.change), 1);
    cyc(12);
    chk("up_code_e16", int'(sif.code), 0);
    chk("up_wrap_e16", int'(sif.wrap), 1);
    cyc(1);
    chk("up_wrap_e17", int'(sif.wrap), 0);

    // Down direction mid-dwell; the next advance (E20) goes 0->3 with wrap.
    sif.dir = 1'b1;
    cyc(3);
    chk("dn_code_e20", int'(sif.code), 3);
    chk("dn_wrap_e20", int'(sif.wrap), 1);
    cyc(12);
    chk("dn_code_e32", int'(sif.code), 0);
    chk("dn_wrap_e32", int'(sif.wrap), 0);

    // Manual stepping: held step gives one advance, second pulse gives another.
    sif.auto_mode = 1'b0;
    sif.dir = 1'b0;
    cyc(1);
    sif.step = 1'b1;
    cyc(1);
    chk("man_code_1", int'(sif.code), 1);
    chk("man_change_1", int'(sif.change), 1);
    cyc(2);
    chk("man_code_hold", int'(sif.code), 1);
    sif.step = 1'b0;
    cyc(1);
    sif.step = 1'b1;
    cyc(1);
    chk("man_code_2", int'(sif.code), 2);
    sif.step = 1'b0;
    cyc(1);
    chk("man_change_off", int'(sif.change), 0);

    // Timed scan from 2: 3 at E44, 0 at E48, 1 at E52; load 3 at the E56 expiry.
    sif.auto_mode = 1'b1;
    cyc(16);
    chk("ld_code_pre", int'(sif.code), 1);
    sif.load = 1'b1;
    sif.load_code = 2'd3;
    cyc(1);
    chk("ld_code", int'(sif.code), 3);
    chk("ld_change", int'(sif.change), 1);
    chk("ld_wrap", int'(sif.wrap), 0);
    sif.load = 1'b0;
    cyc(3);
    chk("ld_hold", int'(sif.code), 3);
    cyc(1);
    chk("ld_next_code", int'(sif.code), 0);
    chk("ld_next_wrap", int'(sif.wrap), 1);

    // Drop en at code 2; a load while disabled is ignored; dwell restarts on re-entry.
    cyc(8);
    chk("en_code_pre", int'(sif.code), 2);
    sif.en = 1'b0;
    cyc(1);
    chk("en_valid_off", int'(sif.code_valid), 0);
    sif.load = 1'b1;
    sif.load_code = 2'd0;
    cyc(1);
    chk("en_load_ignored", int'(sif.code), 2);
    sif.load = 1'b0;
    cyc(1);
    sif.en = 1'b1;
    cyc(1);
    chk("en_valid_on", int'(sif.code_valid), 1);
    chk("en_code_kept", int'(sif.code), 2);
    cyc(3);
    chk("en_code_held", int'(sif.code), 2);
    cyc(1);
    chk("en_code_adv", int'(sif.code), 3);

    // Loading the current value produces no change strobe.
    sif.load = 1'b1;
    sif.load_code = 2'd3;
    cyc(1);
    chk("ld_same_change", int'(sif.change), 0);
    sif.load = 1'b0;

    // Asynchronous reset mid-scan at code 3, checked before any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_code", int'(sif.code), 0);
    chk("arst_x", int'(sif.x), 0);
    chk("arst_y", int'(sif.y), 0);
    chk("arst_valid", int'(sif.code_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);
    chk("rerun_valid", int'(sif.code_valid), 1);
    chk("rerun_code", int'(sif.code), 0);
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
